sar_ctrl: RTL and testbench

SAR_CTRL -- requirements
Module: sar_ctrl

---
 rtl/sar_pkg.sv | 16 +
 rtl/sar_settle_timer.sv | 27 ++
 rtl/sar_ctrl.sv | 139 +++++++++++++
 tb/tb_sar_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and defaults for the successive-approximation ADC controller.
package sar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_SETTLE,
    ST_DECIDE,
    ST_DONE
  } sar_state_t;

  localparam int DEF_N_BITS   = 8;
  localparam int DEF_N_SETTLE = 1;
  localparam int SETTLE_W     = 4;

endpackage

// File: rtl/sar_settle_timer.sv
// Down-counter that times the DAC/comparator settling window for each bit.
module sar_settle_timer
  import sar_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                expired
);

  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A count of one marks the last settle cycle, so the window is exactly load_val cycles long.
  assign expired = (cnt <= SETTLE_W'(1));

endmodule

// File: rtl/sar_ctrl.sv
// SAR ADC conversion controller: sample, then binary-search the DAC code one bit per DECIDE cycle.
module sar_ctrl
  import sar_pkg::*;
#(
  parameter int N_BITS   = DEF_N_BITS,
  parameter int N_SETTLE = DEF_N_SETTLE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cmp_in,
  output logic              sample,
  output logic [N_BITS-1:0] dac_code,
  output logic              cmp_strobe,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] result
);

  localparam int IW = $clog2(N_BITS);
  localparam logic [N_BITS-1:0] MSB_CODE = {1'b1, {(N_BITS-1){1'b0}}};
  localparam logic [IW-1:0] TOP_IDX = IW'(N_BITS - 1);
  localparam bit SKIP_SETTLE = (N_SETTLE == 0);

  sar_state_t        state, state_nx;
  logic [IW-1:0]     idx, idx_nx;
  logic [N_BITS-1:0] code_nx, result_nx;
  logic              done_nx;
  logic              timer_load;
  logic              settle_expired;

  sar_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_W'(N_SETTLE)),
    .expired  (settle_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      dac_code   <= '0;
      result     <= '0;
      done       <= 1'b0;
      sample     <= 1'b0;
      cmp_strobe <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      dac_code   <= code_nx;
      result     <= result_nx;
      done       <= done_nx;
      sample     <= (state_nx == ST_SAMPLE);
      cmp_strobe <= (state_nx == ST_DECIDE);
      busy       <= (state_nx != ST_IDLE);
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    code_nx    = dac_code;
    result_nx  = result;
    done_nx    = 1'b0;
    timer_load = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nx = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        code_nx = MSB_CODE;
        idx_nx  = TOP_IDX;
        if (SKIP_SETTLE) begin
          state_nx = ST_DECIDE;
        end else begin
          state_nx   = ST_SETTLE;
          timer_load = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (settle_expired) begin
          state_nx = ST_DECIDE;
        end
      end

      // cmp_in high means the trial level overshot the input, so the trial bit is dropped.
      ST_DECIDE: begin
        if (cmp_in) begin
          code_nx[idx] = 1'b0;
        end
        if (idx != '0) begin
          code_nx[idx - 1'b1] = 1'b1;
          idx_nx = idx - 1'b1;
          if (SKIP_SETTLE) begin
            state_nx = ST_DECIDE;
          end else begin
            state_nx   = ST_SETTLE;
            timer_load = 1'b1;
          end
        end else begin
          state_nx  = ST_DONE;
          result_nx = code_nx;
          done_nx   = 1'b1;
        end
      end

      ST_DONE: begin
        state_nx = ST_IDLE;
        code_nx  = '0;
      end

      default: begin
        state_nx = ST_IDLE;
        code_nx  = '0;
        idx_nx   = '0;
      end
    endcase

    // DONE is left alone so an abort there cannot swallow the pulse already issued.
    if (abort && (state == ST_SAMPLE || state == ST_SETTLE || state == ST_DECIDE)) begin
      state_nx   = ST_IDLE;
      code_nx    = '0;
      idx_nx     = '0;
      result_nx  = result;
      done_nx    = 1'b0;
      timer_load = 1'b0;
    end
  end

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl: default 8-bit/1-settle instance plus a 12-bit no-settle instance.
module tb_sar_ctrl;

  logic        clk;
  logic        rst_n;

  logic        start, abort, cmp_in;
  logic        sample, cmp_strobe, busy, done;
  logic [7:0]  dac_code, result;
  logic [7:0]  vin;

  logic        start2, abort2, cmp_in2;
  logic        sample2, cmp_strobe2, busy2, done2;
  logic [11:0] dac_code2, result2;
  logic [11:0] vin2;

  int total;
  int bad;
  int done_cnt;
  int strobe2_cnt;

  sar_ctrl #(.N_BITS(8), .N_SETTLE(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cmp_in     (cmp_in),
    .sample     (sample),
    .dac_code   (dac_code),
    .cmp_strobe (cmp_strobe),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  sar_ctrl #(.N_BITS(12), .N_SETTLE(0)) dut_wide (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start2),
    .abort      (abort2),
    .cmp_in     (cmp_in2),
    .sample     (sample2),
    .dac_code   (dac_code2),
    .cmp_strobe (cmp_strobe2),
    .busy       (busy2),
    .done       (done2),
    .result     (result2)
  );

  // Ideal comparator: high when the DAC level is above the held input.
  assign cmp_in  = (dac_code > vin);
  assign cmp_in2 = (dac_code2 > vin2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial done_cnt = 0;
  always @(negedge clk) if (done) done_cnt++;

  initial strobe2_cnt = 0;
  always @(negedge clk) if (cmp_strobe2) strobe2_cnt++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start at edge k, optionally re-pulse start at k+3 and k+10, expect done at k+17.
  task automatic applyStimulus(input logic [7:0] v, input logic [7:0] exp_res,
                               input bit repulse, input string tag);
    int d0;
    vin = v;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({tag, "/sample"}, sample, 1);
    checkOutput({tag, "/busy"}, busy, 1);
    @(posedge clk); #1;
    checkOutput({tag, "/sample_off"}, sample, 0);
    checkOutput({tag, "/msb_code"}, dac_code, 8'h80);
    @(posedge clk); #1;
    checkOutput({tag, "/strobe"}, cmp_strobe, 1);
    for (int e = 3; e <= 16; e++) begin
      start = repulse && (e == 3 || e == 10);
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput({tag, "/done_early"}, done, 0);
    @(posedge clk); #1;
    checkOutput({tag, "/done"}, done, 1);
    checkOutput({tag, "/result"}, result, exp_res);
    @(posedge clk); #1;
    checkOutput({tag, "/done_off"}, done, 0);
    checkOutput({tag, "/dac_zero"}, dac_code, 0);
    checkOutput({tag, "/idle"}, busy, 0);
    checkOutput({tag, "/result_held"}, result, exp_res);
    checkOutput({tag, "/one_pulse"}, done_cnt - d0, 1);
  endtask

  task automatic abortTest();
    int d0;
    d0 = done_cnt;
    vin = 8'h33;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort/busy", busy, 0);
    checkOutput("abort/dac", dac_code, 0);
    checkOutput("abort/strobe", cmp_strobe, 0);
    checkOutput("abort/result", result, 8'h5A);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("abort/no_done", done_cnt - d0, 0);
    checkOutput("abort/still_idle", busy, 0);
    // abort outranks a simultaneous start in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("abort_start/busy", busy, 0);
    checkOutput("abort_start/sample", sample, 0);
  endtask

  task automatic resetTest();
    int d0;
    d0 = done_cnt;
    vin = 8'h77;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst/busy", busy, 0);
    checkOutput("rst/dac", dac_code, 0);
    checkOutput("rst/strobe", cmp_strobe, 0);
    checkOutput("rst/sample", sample, 0);
    checkOutput("rst/result", result, 0);
    checkOutput("rst/done", done, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("rst/no_done", done_cnt - d0, 0);
  endtask

  task automatic wideTest();
    int s0;
    vin2 = 12'hABC;
    s0 = strobe2_cnt;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(posedge clk); #1;
    checkOutput("wide/msb_code", dac_code2, 12'h800);
    checkOutput("wide/strobe", cmp_strobe2, 1);
    repeat (11) @(posedge clk);
    #1;
    checkOutput("wide/done_early", done2, 0);
    @(posedge clk); #1;
    checkOutput("wide/done", done2, 1);
    checkOutput("wide/result", result2, 12'hABC);
    checkOutput("wide/strobe_cycles", strobe2_cnt - s0, 12);
    @(posedge clk); #1;
    checkOutput("wide/dac_zero", dac_code2, 0);
    checkOutput("wide/idle", busy2, 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    vin = 8'h00;
    start2 = 1'b0;
    abort2 = 1'b0;
    vin2 = 12'h000;
    #3;
    checkOutput("reset/busy", busy, 0);
    checkOutput("reset/dac", dac_code, 0);
    checkOutput("reset/result", result, 0);
    checkOutput("reset/done", done, 0);
    checkOutput("reset/sample", sample, 0);
    checkOutput("reset/strobe", cmp_strobe, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    $display("[TB] basic conversions");
    applyStimulus(8'hA5, 8'hA5, 1'b0, "vA5");
    applyStimulus(8'h00, 8'h00, 1'b0, "v00");
    applyStimulus(8'hFF, 8'hFF, 1'b0, "vFF");
    applyStimulus(8'h5A, 8'h5A, 1'b1, "repulse");

    $display("[TB] abort handling");
    abortTest();
    applyStimulus(8'h33, 8'h33, 1'b0, "after_abort");

    $display("[TB] reset mid-conversion");
    resetTest();
    applyStimulus(8'h3C, 8'h3C, 1'b0, "after_reset");

    $display("[TB] 12-bit, no settle");
    wideTest();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
